// File: rtl/tp_ram_pkg.sv
// Shared types and constants for the RAM read streamer.
// Holds the sequencer state encoding and the default RAM latency.
package tp_ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  localparam int TP_RD_LAT_DEF = 2;

endpackage

// File: rtl/rd_skid_fifo.sv
// Small shift-register skid FIFO with a registered head entry.
// Absorbs read data returning from the RAM while the consumer stalls.
module rd_skid_fifo #(
  parameter int W = 16,
  parameter int D = 4,
  localparam int CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          valid,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [D];
  logic [CW-1:0] cnt;
  logic          pop_en;
  logic [CW-1:0] widx;

  assign pop_en = pop && (cnt != '0);
  assign widx   = pop_en ? cnt - CW'(1) : cnt;
  assign rdata  = mem[0];
  assign valid  = (cnt != '0);
  assign count  = cnt;

  // Occupancy: simultaneous push and pop leave it unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(push) - CW'(pop_en);
    end
  end

  // Storage: entries shift toward the head on pop, push lands behind the last
  always_ff @(posedge clk) begin
    if (pop_en) begin
      for (int i = 0; i < D - 1; i++) begin
        mem[i] <= mem[i+1];
      end
    end
    for (int i = 0; i < D; i++) begin
      if (push && !flush && widx == CW'(i)) begin
        mem[i] <= wdata;
      end
    end
  end

endmodule

// File: rtl/tp_ram_rd_stream.sv
// Burst reader: streams len words from a latency-LAT RAM into a ready/valid port.
// Optional feature macro: TP_RD_STREAM_LAST_EN adds out_last on the final beat.
module tp_ram_rd_stream
  import tp_ram_pkg::*;
#(
  parameter int AW  = 8,
  parameter int DW  = 16,
  parameter int LAT = TP_RD_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_radr,
  input  logic [DW-1:0] ram_rdat,
  output logic          out_valid,
  input  logic          out_ready,
`ifdef TP_RD_STREAM_LAST_EN
  output logic          out_last,
`endif
  output logic [DW-1:0] out_data
);

  localparam int DEPTH = LAT + 2;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef TP_RD_STREAM_LAST_EN
  localparam int FW    = DW + 1;
`else
  localparam int FW    = DW;
`endif

  rd_state_t     state;
  logic [AW-1:0] addr;
  logic [AW:0]   rem;
  logic [LAT-1:0] vpipe;
  logic          done_z;
  logic [7:0]    inflight;
  logic [CW-1:0] fifo_cnt;
  logic          issue;
  logic          drained;
  logic          is_last;
  logic [FW-1:0] push_data;
  logic [FW-1:0] head;
`ifdef TP_RD_STREAM_LAST_EN
  logic [LAT-1:0] lpipe;
`endif

  // Reads currently travelling through the RAM
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + 8'(vpipe[i]);
    end
  end

  assign issue   = (state == RUN) && !abort &&
                   ((inflight + 8'(fifo_cnt)) < 8'(DEPTH));
  assign is_last = issue && (rem == (AW+1)'(1));
  assign drained = (inflight == '0) && (fifo_cnt == '0);
  assign busy    = (state != IDLE);
  assign done    = done_z || ((state == DRAIN) && drained);
  assign ram_radr = addr;

  // Sequencer: burst bookkeeping, read issue and the in-flight valid pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr   <= '0;
      rem    <= '0;
      vpipe  <= '0;
      done_z <= 1'b0;
`ifdef TP_RD_STREAM_LAST_EN
      lpipe  <= '0;
`endif
    end else if (abort) begin
      state  <= IDLE;
      vpipe  <= '0;
      done_z <= 1'b0;
`ifdef TP_RD_STREAM_LAST_EN
      lpipe  <= '0;
`endif
    end else begin
      done_z <= 1'b0;
      vpipe  <= LAT'({vpipe, issue});
`ifdef TP_RD_STREAM_LAST_EN
      lpipe  <= LAT'({lpipe, is_last});
`endif
      unique case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              done_z <= 1'b1;
            end else begin
              addr  <= base;
              rem   <= len;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (issue) begin
            addr <= addr + AW'(1);
            rem  <= rem - (AW+1)'(1);
            if (is_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drained) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TP_RD_STREAM_LAST_EN
  assign push_data = {lpipe[LAT-1], ram_rdat};
  assign out_last  = head[DW];
`else
  assign push_data = ram_rdat;
`endif
  assign out_data = head[DW-1:0];

  rd_skid_fifo #(
    .W (FW),
    .D (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (vpipe[LAT-1]),
    .wdata (push_data),
    .pop   (out_ready),
    .rdata (head),
    .valid (out_valid),
    .count (fifo_cnt)
  );

endmodule

// File: tb/tb_tp_ram_rd_stream.sv
// Scoreboard bench for tp_ram_rd_stream with a behavioural latency RAM.
// Define TP_RD_STREAM_LAST_EN to also check out_last.
module tb_tp_ram_rd_stream;

  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   len;
  logic          abort;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_radr;
  logic [DW-1:0] ram_rdat;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
`ifdef TP_RD_STREAM_LAST_EN
  logic          out_last;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int exp_done = 0;
  int done_seen = 0;
  int rdy_mode = 0;

  logic [DW-1:0] mem [256];
  logic [AW-1:0] adr_d [LAT];
  logic [DW:0]   sb [$];
  logic [DW:0]   h;

  logic          busy_q = 1'b0;
  logic [AW-1:0] radr_q = '0;
  int iss = 0;
  int popn = 0;
  int max_out = 0;
  int last_iss = 0;

  tp_ram_rd_stream #(
    .AW  (AW),
    .DW  (DW),
    .LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base      (base),
    .len       (len),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .ram_radr  (ram_radr),
    .ram_rdat  (ram_rdat),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef TP_RD_STREAM_LAST_EN
    .out_last  (out_last),
`endif
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // RAM: the word at the address shown in cycle N appears in cycle N+LAT
  always @(posedge clk) begin
    adr_d[0] <= ram_radr;
    for (int i = 1; i < LAT; i++) adr_d[i] <= adr_d[i-1];
  end
  assign ram_rdat = mem[adr_d[LAT-1]];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Consumer ready pattern
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      2: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: head must match the oldest expected beat whenever valid
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL beat_unexpected: got %0h, none expected", out_data);
      end else begin
        h = sb[0];
        chk("beat_data", 32'(out_data), 32'(h[DW-1:0]));
`ifdef TP_RD_STREAM_LAST_EN
        chk("beat_last", 32'(out_last), 32'(h[DW]));
`endif
        if (out_ready) void'(sb.pop_front());
      end
    end
    if (done) done_seen++;
  end

  // Outstanding reads: issues seen as address steps minus accepted beats
  always @(negedge clk) begin
    if (busy && busy_q && ram_radr != radr_q) iss++;
    if (iss - popn > max_out) max_out = iss - popn;
    if (out_valid && out_ready) popn++;
    if (!busy) begin
      if (busy_q) last_iss = iss;
      iss = 0;
      popn = 0;
    end
    busy_q = busy;
    radr_q = ram_radr;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [AW-1:0] b, input logic [AW:0] l);
    logic [AW-1:0] a;
    base  = b;
    len   = l;
    start = 1'b1;
    for (int i = 0; i < int'(l); i++) begin
      a = b + AW'(i);
      sb.push_back({1'(i == int'(l) - 1), mem[a]});
    end
    exp_done++;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int lim);
    logic seen = 1'b0;
    for (int k = 0; k < lim && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    chk(nm, 32'(seen), 32'(1));
    tick(1);
  endtask

  task automatic chk_reads(input string nm, input int n);
    @(negedge clk);
    #1;
    chk(nm, 32'(last_iss), 32'(n));
    tick(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    base  = '0;
    len   = '0;
    out_ready = 1'b1;
    #2;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_radr", 32'(ram_radr), 32'(0));
    #20;
    rst_n = 1'b1;
    tick(2);
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_valid", 32'(out_valid), 32'(0));

    // Reference timeline: base 0x10, four beats, consumer always ready
    launch(8'h10, 9'd4);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k <= 4) chk("t39_radr", 32'(ram_radr), 32'(16 + k - 1));
      chk("t39_valid", 32'(out_valid), 32'(k >= 4 && k <= 7));
      chk("t39_done", 32'(done), 32'(k == 8));
    end
    tick(1);

    // Zero-length request completes at once and touches nothing
    launch(8'h40, 9'd0);
    @(negedge clk);
    chk("t40_done", 32'(done), 32'(1));
    chk("t40_busy", 32'(busy), 32'(0));
    chk("t40_valid", 32'(out_valid), 32'(0));
    chk("t40_radr", 32'(ram_radr), 32'(8'h14));
    @(negedge clk);
    chk("t40_done_off", 32'(done), 32'(0));
    chk("t40_radr2", 32'(ram_radr), 32'(8'h14));
    tick(1);

    // Address wrap
    launch(8'hFF, 9'd3);
    wait_done("t41_done", 30);
    chk_reads("t41_reads", 3);

    // Stalling consumer: toggle, then hold off, then drain
    rdy_mode = 1;
    launch(8'h80, 9'd16);
    tick(12);
    rdy_mode = 2;
    tick(10);
    rdy_mode = 0;
    wait_done("t42_done", 100);
    chk_reads("t42_reads", 16);
    chk("t42_sb_empty", 32'(sb.size()), 32'(0));

    // Abort in cycle 3 of an eight-beat burst
    launch(8'h20, 9'd8);
    tick(1);
    abort = 1'b1;
    sb.delete();
    exp_done--;
    tick(1);
    abort = 1'b0;
    for (int k = 4; k <= 8; k++) begin
      @(negedge clk);
      chk("t43_valid", 32'(out_valid), 32'(0));
      chk("t43_busy", 32'(busy), 32'(0));
    end
    tick(1);
    launch(8'h30, 9'd5);
    wait_done("t43_restart_done", 40);
    chk_reads("t43_restart_reads", 5);

    // Abort and start together: start is dropped
    base  = 8'h60;
    len   = 9'd5;
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t31_busy", 32'(busy), 32'(0));
      chk("t31_valid", 32'(out_valid), 32'(0));
    end
    tick(1);

    // Reset in the middle of a burst
    rdy_mode = 3;
    launch(8'h50, 9'd20);
    tick(6);
    rst_n = 1'b0;
    sb.delete();
    exp_done--;
    #1;
    chk("mrst_busy", 32'(busy), 32'(0));
    chk("mrst_valid", 32'(out_valid), 32'(0));
    chk("mrst_done", 32'(done), 32'(0));
    chk("mrst_radr", 32'(ram_radr), 32'(0));
    #2;
    rst_n = 1'b1;
    tick(2);

    // Randomised bursts with a random consumer
    for (int n = 0; n < 20; n++) begin
      launch(AW'($urandom), (AW+1)'($urandom_range(0, 12)));
      wait_done("rnd_done", 300);
    end

    // Full address space in one burst
    rdy_mode = 0;
    launch(8'h07, 9'd256);
    wait_done("full_done", 600);
    chk_reads("full_reads", 256);

    tick(3);
    chk("sb_empty", 32'(sb.size()), 32'(0));
    chk("done_count", 32'(done_seen), 32'(exp_done));
    chk("max_outstanding", 32'(max_out <= LAT + 2), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
